// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end for the PWM register interface: oversamples the SPI pins
// on clk, deserialises MOSI into bytes and serialises data_out onto MISO.
module spi_bridge #(
  parameter int SCLK_RATIO_MIN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       byte_sync,
  output logic [7:0] data_in,
  input  logic [7:0] data_out
);

  logic       sclk_m, sclk_s, sclk_d;
  logic       cs_m, cs_s, cs_d;
  logic       mosi_m, mosi_s;
  logic [6:0] rx;
  logic [7:0] tx;
  logic [2:0] bit_cnt;
  logic       rise, fall, active, cs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      cs_d   <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      cs_m   <= cs_n;
      cs_s   <= cs_m;
      cs_d   <= cs_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign active  = ~cs_s;
  assign cs_fall = ~cs_s & cs_d;

  // Deselect has priority over any sclk edge seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx        <= '0;
      tx        <= '0;
      bit_cnt   <= '0;
      data_in   <= '0;
      byte_sync <= 1'b0;
    end else if (!active) begin
      rx        <= '0;
      bit_cnt   <= '0;
      byte_sync <= 1'b0;
    end else begin
      byte_sync <= 1'b0;
      if (rise) begin
        rx      <= {rx[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_in   <= {rx, mosi_s};
          byte_sync <= 1'b1;
        end
      end
      if (cs_fall || (fall && bit_cnt == 3'd0))
        tx <= data_out;
      else if (fall)
        tx <= {tx[6:0], 1'b0};
    end
  end

  assign miso = active & tx[7];

  // Consecutive sclk rises must be at least half the minimum ratio apart.
  for (genvar i = 1; i < SCLK_RATIO_MIN / 2; i++) begin : g_rate_chk
    assert property (@(posedge clk) disable iff (!rst_n) rise |-> !$past(rise, i));
  end

endmodule
